// File: rtl/tetrix_tick_gen_if.sv
// -----------------------------------------------------------------------------
// tetrix_tick_gen_if
// Divisor-programming bus for tetrix_tick_gen.
//   div_we  : one-cycle write strobe
//   div_sel : target channel index (writes to indices >= NUM_CH are dropped)
//   div_val : new divisor; the channel period becomes div_val+1 cycles
// master drives the bus (controller / testbench), slave is the tick generator.
// -----------------------------------------------------------------------------
interface tetrix_tick_gen_if #(
    parameter int unsigned DIV_W = 24
);
    logic             div_we;
    logic [3:0]       div_sel;
    logic [DIV_W-1:0] div_val;

    modport master (output div_we, output div_sel, output div_val);
    modport slave  (input  div_we, input  div_sel, input  div_val);
endinterface

// File: rtl/tetrix_tick_gen.sv
// -----------------------------------------------------------------------------
// tetrix_tick_gen
// Reset stretcher plus NUM_CH independent programmable periodic tick channels.
//
// Ports:
//   clk_in      : system clock, all logic on the rising edge
//   rst         : synchronous active-low reset
//   run         : 1 = channels count, 0 = counters frozen and ticks suppressed
//   cfg         : divisor write bus (tetrix_tick_gen_if.slave)
//   sys_rst_out : active-high reset held RST_HOLD edges past rst release
//   tick        : one-cycle pulse per channel period (div+1 cycles)
//   phase       : per-channel toggle on every tick (50% square wave)
//
// Build option:
//   TICK_ALIGN_EN : any accepted divisor write restarts every channel and
//                   clears all phase bits, keeping channels phase-aligned.
// -----------------------------------------------------------------------------
module tetrix_tick_gen #(
    parameter int unsigned      NUM_CH      = 4,
    parameter int unsigned      DIV_W       = 24,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(999_999),
    parameter int unsigned      RST_HOLD    = 16
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                run,
    tetrix_tick_gen_if.slave    cfg,
    output logic                sys_rst_out,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   phase
);

    localparam int unsigned HOLD_W = 8;

    // Reset stretch state
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              sys_rst_q,  sys_rst_d;

    // Per-channel state
    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  div_d [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q,  tick_d;
    logic [NUM_CH-1:0] phase_q, phase_d;

    // Decoded write controls
    logic              write_ok;
    logic              count_en;
    logic [DIV_W-1:0]  wr_val;
    logic [NUM_CH-1:0] sel_hit;
    logic [NUM_CH-1:0] clr_ch;

    assign wr_val = cfg.div_val;

    // Write decode: out-of-range channel indices are silently dropped.
    always_comb begin
        write_ok = cfg.div_we && (32'(cfg.div_sel) < NUM_CH);
        sel_hit  = '0;
        clr_ch   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sel_hit[i] = write_ok && (32'(cfg.div_sel) == i);
`ifdef TICK_ALIGN_EN
            clr_ch[i]  = write_ok;
`else
            clr_ch[i]  = sel_hit[i];
`endif
        end
    end

    // Reset stretch: sys_rst falls on the RST_HOLD-th edge with rst released.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        sys_rst_d  = sys_rst_q;
        if (sys_rst_q) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
                sys_rst_d = 1'b0;
            end
        end
    end

    // Channels count only once the stretched reset has dropped.
    assign count_en = run && !sys_rst_q;

    // Channel next state; a write beats a simultaneous terminal count.
    always_comb begin
        tick_d  = '0;
        phase_d = phase_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            div_d[i] = div_q[i];
            cnt_d[i] = cnt_q[i];
            if (sel_hit[i]) begin
                div_d[i] = wr_val;
            end
            if (clr_ch[i]) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b0;
`ifdef TICK_ALIGN_EN
                phase_d[i] = 1'b0;
`endif
            end else if (count_en) begin
                if (cnt_q[i] == div_q[i]) begin
                    cnt_d[i]   = '0;
                    tick_d[i]  = 1'b1;
                    phase_d[i] = ~phase_q[i];
                end else begin
                    cnt_d[i]   = cnt_q[i] + DIV_W'(1);
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            hold_cnt_q <= '0;
            sys_rst_q  <= 1'b1;
            tick_q     <= '0;
            phase_q    <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DEFAULT_DIV;
                cnt_q[i] <= '0;
            end
        end else begin
            hold_cnt_q <= hold_cnt_d;
            sys_rst_q  <= sys_rst_d;
            tick_q     <= tick_d;
            phase_q    <= phase_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sys_rst_out = sys_rst_q;
    assign tick        = tick_q;
    assign phase       = phase_q;

endmodule

// File: tb/tb_tetrix_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_tetrix_tick_gen
// Directed scenarios followed by random traffic, every edge compared against
// a behavioural model that tracks "edges remaining until the next tick".
// -----------------------------------------------------------------------------
module tb_tetrix_tick_gen;

    localparam int unsigned      NUM_CH   = 4;
    localparam int unsigned      DIV_W    = 24;
    localparam int unsigned      RST_HOLD = 16;
    localparam logic [DIV_W-1:0] DEF_DIV  = 24'd13;
`ifdef TICK_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              sys_rst_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] phase;

    always #5 clk = ~clk;

    tetrix_tick_gen_if #(.DIV_W(DIV_W)) bus ();

    tetrix_tick_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF_DIV),
        .RST_HOLD    (RST_HOLD)
    ) dut (
        .clk_in      (clk),
        .rst         (rst),
        .run         (run),
        .cfg         (bus),
        .sys_rst_out (sys_rst_out),
        .tick        (tick),
        .phase       (phase)
    );

    int total = 0;
    int bad   = 0;

    // Reference model
    int unsigned       m_div  [NUM_CH];
    int unsigned       m_rem  [NUM_CH];
    logic [NUM_CH-1:0] m_tick  = '0;
    logic [NUM_CH-1:0] m_phase = '0;
    int unsigned       m_since = 0;
    bit                m_srst  = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at it.
    task automatic model_edge();
        bit          en;
        bit          wr;
        int unsigned sel;
        sel = 32'(bus.div_sel);
        en  = run && !m_srst;
        wr  = bus.div_we && (sel < NUM_CH);
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = 32'(DEF_DIV);
                m_rem[i] = 32'(DEF_DIV);
            end
            m_tick  = '0;
            m_phase = '0;
            m_since = 0;
            m_srst  = 1'b1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr && (ALIGN || (32'(i) == sel))) begin
                    if (32'(i) == sel) m_div[i] = 32'(bus.div_val);
                    m_rem[i]  = m_div[i];
                    m_tick[i] = 1'b0;
                    if (ALIGN) m_phase[i] = 1'b0;
                end else if (en) begin
                    if (m_rem[i] == 0) begin
                        m_tick[i]  = 1'b1;
                        m_phase[i] = ~m_phase[i];
                        m_rem[i]   = m_div[i];
                    end else begin
                        m_tick[i] = 1'b0;
                        m_rem[i]  = m_rem[i] - 1;
                    end
                end else begin
                    m_tick[i] = 1'b0;
                end
            end
            if (m_srst) begin
                m_since++;
                if (m_since >= RST_HOLD) m_srst = 1'b0;
            end
        end
    endtask

    // Apply inputs, clock one edge, then compare all outputs to the model.
    task automatic cyc(input logic r, input logic rn, input logic we,
                       input logic [3:0] sel, input int unsigned val);
        rst         = r;
        run         = rn;
        bus.div_we  = we;
        bus.div_sel = sel;
        bus.div_val = DIV_W'(val);
        @(posedge clk);
        model_edge();
        #1;
        chk("sys_rst_out", 32'(sys_rst_out), 32'(m_srst));
        chk("tick",        32'(tick),        32'(m_tick));
        chk("phase",       32'(phase),       32'(m_phase));
    endtask

    initial begin
        int          n;
        int          cnt0;
        int          cnt1;
        int          diffs;
        logic        ph0;
        logic        r;
        logic        rn;
        logic        we;
        logic [3:0]  sel;

        // Reset stretch: 5 reset edges, then measure release length.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 0);
        n = 0;
        do begin
            cyc(1'b1, 1'b0, 1'b0, 4'd0, 0);
            n++;
        end while (sys_rst_out === 1'b1 && n < 100);
        chk("rst_len", 32'(n), 32'(RST_HOLD));

        // Reset re-asserted at the 8th edge restarts the stretch.
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 0);
        n = 0;
        do begin
            cyc(1'b1, 1'b0, 1'b0, 4'd0, 0);
            n++;
        end while (sys_rst_out === 1'b1 && n < 100);
        chk("rst_restart_len", 32'(n), 32'(RST_HOLD));

        // Period: ch0 div=3, ch1 div=0.
        cyc(1'b1, 1'b1, 1'b1, 4'd0, 3);
        cyc(1'b1, 1'b1, 1'b1, 4'd1, 0);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 4'd0, 0);
            cnt0 += int'(tick[0]);
            cnt1 += int'(tick[1]);
        end
        chk("ch0_ticks16", 32'(cnt0), 32'd4);
        chk("ch1_ticks16", 32'(cnt1), 32'd16);

        // Freeze: ch2 div=9, drop run at cnt=5 for 20 cycles.
        cyc(1'b1, 1'b1, 1'b1, 4'd2, 9);
        n = 0;
        while (m_rem[2] != 4 && n < 50) begin
            cyc(1'b1, 1'b1, 1'b0, 4'd0, 0);
            n++;
        end
        cnt0 = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd0, 0);
            cnt0 += int'(tick != '0);
        end
        chk("frozen_ticks", 32'(cnt0), 32'd0);
        n = 0;
        do begin
            cyc(1'b1, 1'b1, 1'b0, 4'd0, 0);
            n++;
        end while (tick[2] !== 1'b1 && n < 50);
        chk("resume_latency", 32'(n), 32'd5);

        // Collision: rewrite ch0 on its terminal-count edge.
        n = 0;
        while (m_rem[0] != 0 && n < 50) begin
            cyc(1'b1, 1'b1, 1'b0, 4'd0, 0);
            n++;
        end
        ph0 = phase[0];
        cyc(1'b1, 1'b1, 1'b1, 4'd0, 7);
        chk("collide_tick", 32'(tick[0]), 32'd0);
        chk("collide_phase", 32'(phase[0]), ALIGN ? 32'd0 : 32'(ph0));
        n = 0;
        do begin
            cyc(1'b1, 1'b1, 1'b0, 4'd0, 0);
            n++;
        end while (tick[0] !== 1'b1 && n < 50);
        chk("collide_next", 32'(n), 32'd8);

        // Out-of-range channel write must not disturb anything.
        cyc(1'b1, 1'b1, 1'b1, 4'd15, 2);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 4'd0, 0);

        // Alignment: ch1/ch3 div=4 with offset counts, then rewrite ch1.
        cyc(1'b1, 1'b1, 1'b1, 4'd1, 4);
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 0);
        cyc(1'b1, 1'b1, 1'b1, 4'd3, 4);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 4'd0, 0);
        cyc(1'b1, 1'b1, 1'b1, 4'd1, 4);
        diffs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 4'd0, 0);
            diffs += int'(tick[1] != tick[3]);
        end
        chk("align_diffs", 32'(diffs), ALIGN ? 32'd0 : 32'd8);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 299) != 0);
            rn  = ($urandom_range(0, 9) != 0);
            we  = ($urandom_range(0, 7) == 0);
            sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(0, 3));
            cyc(r, rn, we, sel, $urandom_range(0, 12));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
